// File: rtl/sdram_read_write_arbiter.sv
// sdram_read_write_arbiter
// Shares one 64-bit Avalon-MM SDRAM master between port A (scan-out reader,
// reads only, highest priority) and port B (rasterizer, reads and writes).
// A 1-bit tag FIFO records which port issued each read so returned data is
// steered back in issue order.
// Optional feature: define SDRAM_ARBITER_STARVATION_GUARD_EN to force B one
// accepted command after MAX_A_RUN consecutive A acceptances while B waits.
module sdram_read_write_arbiter #(
    parameter int unsigned TAG_DEPTH      = 64,
    parameter int unsigned TAG_DEPTH_LOG2 = 6,
    parameter int unsigned MAX_A_RUN      = 32
) (
    input  logic        clock,
    input  logic        reset,
    // port A: frame-buffer scan-out
    input  logic [28:0] a_address,
    input  logic        a_read,
    output logic        a_waitrequest,
    output logic [63:0] a_readdata,
    output logic        a_readdatavalid,
    // port B: rasterizer
    input  logic [28:0] b_address,
    input  logic        b_read,
    input  logic        b_write,
    input  logic [63:0] b_writedata,
    input  logic [7:0]  b_byteenable,
    output logic        b_waitrequest,
    output logic [63:0] b_readdata,
    output logic        b_readdatavalid,
    // SDRAM master
    output logic [28:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_writedata,
    output logic [7:0]  mem_byteenable,
    output logic [7:0]  mem_burstcount,
    input  logic        mem_waitrequest,
    input  logic [63:0] mem_readdata,
    input  logic        mem_readdatavalid,
    output logic        err_unexpected_data
);

    localparam logic        OWN_A = 1'b0;
    localparam logic        OWN_B = 1'b1;
    localparam int unsigned CNT_W = TAG_DEPTH_LOG2 + 1;

    logic                      owner_q;
    logic                      owner_d;
    logic [TAG_DEPTH-1:0]      tag_q;
    logic [TAG_DEPTH_LOG2-1:0] wr_ptr_q;
    logic [TAG_DEPTH_LOG2-1:0] rd_ptr_q;
    logic [CNT_W-1:0]          tag_cnt_q;
    logic                      err_q;

    logic own_read_c;
    logic own_write_c;
    logic tags_full_c;
    logic tags_empty_c;
    logic own_wait_c;
    logic accept_c;
    logic push_c;
    logic pop_c;
    logic head_c;
    logic handover_c;
    logic b_req_c;
    logic a_accept_c;
    logic b_accept_c;
    logic guard_trip_c;

    // Command path: mux the owner's command onto the master, stall the other port.
    always_comb begin
        own_read_c   = (owner_q == OWN_B) ? b_read : a_read;
        own_write_c  = (owner_q == OWN_B) & b_write;
        tags_full_c  = (tag_cnt_q == CNT_W'(TAG_DEPTH));
        tags_empty_c = (tag_cnt_q == '0);
        own_wait_c   = mem_waitrequest | (own_read_c & tags_full_c);
        accept_c     = (own_read_c | own_write_c) & ~own_wait_c;
        push_c       = accept_c & own_read_c;
        pop_c        = mem_readdatavalid & ~tags_empty_c;
        head_c       = tag_q[rd_ptr_q];
        handover_c   = ~(own_read_c | own_write_c) | accept_c;
        b_req_c      = b_read | b_write;
        a_accept_c   = accept_c & (owner_q == OWN_A);
        b_accept_c   = accept_c & (owner_q == OWN_B);

        mem_read       = ~reset & own_read_c & ~tags_full_c;
        mem_write      = ~reset & own_write_c;
        mem_address    = (owner_q == OWN_B) ? b_address : a_address;
        mem_writedata  = b_writedata;
        mem_byteenable = (owner_q == OWN_B) ? b_byteenable : 8'hFF;
        mem_burstcount = 8'h01;

        a_waitrequest  = reset | (owner_q != OWN_A) | own_wait_c;
        b_waitrequest  = reset | (owner_q != OWN_B) | own_wait_c;

        a_readdata      = mem_readdata;
        b_readdata      = mem_readdata;
        a_readdatavalid = ~reset & pop_c & (head_c == OWN_A);
        b_readdatavalid = ~reset & pop_c & (head_c == OWN_B);

        err_unexpected_data = err_q;
    end

`ifdef SDRAM_ARBITER_STARVATION_GUARD_EN
    localparam int unsigned RUN_W = $clog2(MAX_A_RUN + 1);

    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    // Count A acceptances while B waits; saturate at the limit, clear once B gets through or gives up.
    always_comb begin
        run_d = run_q;
        if (b_accept_c || !b_req_c) begin
            run_d = '0;
        end else if (a_accept_c && (run_q != RUN_W'(MAX_A_RUN))) begin
            run_d = run_q + RUN_W'(1);
        end
        guard_trip_c = (run_d == RUN_W'(MAX_A_RUN));
    end

    // Run counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end
`else
    logic [31:0] unused_max_a_run;
    assign unused_max_a_run = 32'(MAX_A_RUN);
    assign guard_trip_c     = 1'b0;
`endif

    // Owner selection: only at a handover point, A first unless the guard forces B.
    always_comb begin
        owner_d = owner_q;
        if (handover_c) begin
            if (a_read && !guard_trip_c) begin
                owner_d = OWN_A;
            end else if (b_req_c) begin
                owner_d = OWN_B;
            end
        end
    end

    // Owner register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q <= OWN_A;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Tag FIFO: one requester bit per outstanding read, oldest at rd_ptr.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tag_cnt_q <= '0;
        end else begin
            if (push_c) begin
                tag_q[wr_ptr_q] <= owner_q;
                wr_ptr_q        <= wr_ptr_q + TAG_DEPTH_LOG2'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + TAG_DEPTH_LOG2'(1);
            end
            case ({push_c, pop_c})
                2'b10:   tag_cnt_q <= tag_cnt_q + CNT_W'(1);
                2'b01:   tag_cnt_q <= tag_cnt_q - CNT_W'(1);
                default: tag_cnt_q <= tag_cnt_q;
            endcase
        end
    end

    // Sticky flag for read data arriving with nothing outstanding; the word is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (mem_readdatavalid && tags_empty_c) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_read_write_arbiter.sv
// Self-checking bench for sdram_read_write_arbiter: a per-cycle behavioural
// model (owner, tag queue, A-run count) plus an in-order memory model with
// configurable latency, directed scenarios and a randomized phase.
`timescale 1ns/1ps
module tb_sdram_read_write_arbiter;

    localparam int TAG_DEPTH = 64;
    localparam int MAX_A_RUN = 32;
`ifdef SDRAM_ARBITER_STARVATION_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [28:0] a_address = '0;
    logic        a_read = 1'b0;
    logic        a_waitrequest;
    logic [63:0] a_readdata;
    logic        a_readdatavalid;
    logic [28:0] b_address = '0;
    logic        b_read = 1'b0;
    logic        b_write = 1'b0;
    logic [63:0] b_writedata = '0;
    logic [7:0]  b_byteenable = '0;
    logic        b_waitrequest;
    logic [63:0] b_readdata;
    logic        b_readdatavalid;
    logic [28:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_writedata;
    logic [7:0]  mem_byteenable;
    logic [7:0]  mem_burstcount;
    logic        mem_waitrequest = 1'b0;
    logic [63:0] mem_readdata = '0;
    logic        mem_readdatavalid = 1'b0;
    logic        err_unexpected_data;

    sdram_read_write_arbiter dut (
        .clock(clock), .reset(reset),
        .a_address(a_address), .a_read(a_read), .a_waitrequest(a_waitrequest),
        .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_read(b_read), .b_write(b_write),
        .b_writedata(b_writedata), .b_byteenable(b_byteenable),
        .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
        .b_readdatavalid(b_readdatavalid),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_burstcount(mem_burstcount), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
        .err_unexpected_data(err_unexpected_data)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_data(input logic [28:0] ad);
        return {3'b000, ad, 3'b101, ~ad};
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Memory model: in-order read returns, each no earlier than its due cycle.
    typedef struct { int due; logic [63:0] data; } mem_ent_t;
    mem_ent_t memq[$];
    bit ret_en  = 1'b1;
    int mem_lat = 3;
    bit inject  = 1'b0;

    always @(posedge clock) begin
        #1;
        mem_readdatavalid = 1'b0;
        mem_readdata      = {$urandom, $urandom};
        if (inject) begin
            mem_readdatavalid = 1'b1;
            inject = 1'b0;
        end else if (!reset && ret_en && memq.size() > 0 && memq[0].due <= cyc) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = memq[0].data;
            void'(memq.pop_front());
        end
    end

    // Reference model state
    bit          m_holder = 1'b0;   // 0 = A holds the master, 1 = B
    bit          m_tags[$];
    int          m_run = 0;
    bit          m_err = 1'b0;
    logic [63:0] a_expq[$];
    logic [63:0] b_expq[$];

    // Observed events for the directed scenarios
    bit a_acc_now = 1'b0;
    bit b_acc_now = 1'b0;
    int n_a_acc = 0, n_b_acc = 0, n_a_rdv = 0, n_b_rdv = 0;
    bit ret_order[$];

    // Compare process: predict every output from the model, then advance the model.
    always @(negedge clock) begin
        bit o_rd, o_wr, full, wait_o, acc, bq, ho, trip, e_ardv, e_brdv;
        logic [28:0] o_addr;
        logic [63:0] d;
        a_acc_now = a_read && !a_waitrequest && !reset;
        b_acc_now = (b_read || b_write) && !b_waitrequest && !reset;
        if (a_acc_now) n_a_acc++;
        if (b_acc_now) n_b_acc++;
        if (a_readdatavalid) begin n_a_rdv++; ret_order.push_back(1'b0); end
        if (b_readdatavalid) begin n_b_rdv++; ret_order.push_back(1'b1); end
        if (reset) begin
            chk("rst_mem_read", mem_read, 0);
            chk("rst_mem_write", mem_write, 0);
            chk("rst_a_wait", a_waitrequest, 1);
            chk("rst_b_wait", b_waitrequest, 1);
            chk("rst_a_rdv", a_readdatavalid, 0);
            chk("rst_b_rdv", b_readdatavalid, 0);
            chk("rst_err", err_unexpected_data, 0);
            m_holder = 1'b0; m_tags.delete(); m_run = 0; m_err = 1'b0;
            memq.delete(); a_expq.delete(); b_expq.delete();
        end else begin
            o_rd   = m_holder ? b_read : a_read;
            o_wr   = m_holder ? b_write : 1'b0;
            o_addr = m_holder ? b_address : a_address;
            full   = (m_tags.size() >= TAG_DEPTH);
            wait_o = mem_waitrequest || (o_rd && full);
            acc    = (o_rd || o_wr) && !wait_o;
            chk("mem_read", mem_read, o_rd && !full);
            chk("mem_write", mem_write, o_wr);
            chk("mem_burstcount", mem_burstcount, 8'h01);
            if (o_rd || o_wr) begin
                chk("mem_address", mem_address, o_addr);
                chk("mem_byteenable", mem_byteenable, m_holder ? b_byteenable : 8'hFF);
            end
            if (o_wr) chk("mem_writedata", mem_writedata, b_writedata);
            chk("a_waitrequest", a_waitrequest, m_holder ? 1'b1 : wait_o);
            chk("b_waitrequest", b_waitrequest, m_holder ? wait_o : 1'b1);
            e_ardv = mem_readdatavalid && m_tags.size() > 0 && m_tags[0] == 1'b0;
            e_brdv = mem_readdatavalid && m_tags.size() > 0 && m_tags[0] == 1'b1;
            chk("a_readdatavalid", a_readdatavalid, e_ardv);
            chk("b_readdatavalid", b_readdatavalid, e_brdv);
            chk("err_unexpected_data", err_unexpected_data, m_err);
            if (e_ardv) chk("a_readdata", a_readdata, a_expq.pop_front());
            if (e_brdv) chk("b_readdata", b_readdata, b_expq.pop_front());
            if (mem_readdatavalid) begin
                if (m_tags.size() == 0) m_err = 1'b1;
                else void'(m_tags.pop_front());
            end
            if (acc && o_rd) begin
                d = mk_data(o_addr);
                m_tags.push_back(m_holder);
                if (m_holder) b_expq.push_back(d); else a_expq.push_back(d);
                memq.push_back('{cyc + mem_lat, d});
            end
            bq = b_read || b_write;
            if ((acc && m_holder) || !bq) m_run = 0;
            else if (acc && !m_holder && m_run < MAX_A_RUN) m_run++;
            trip = GUARD && (m_run >= MAX_A_RUN);
            ho   = !(o_rd || o_wr) || acc;
            if (ho) begin
                if (a_read && !trip) m_holder = 1'b0;
                else if (bq) m_holder = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (m_tags.size() == 0 && memq.size() == 0) begin ok = 1'b1; break; end
            tick();
        end
        chk("drain_timeout", ok, 1);
        tick(); tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) tick();
        reset = 1'b0;
    endtask

    initial begin
        int cnt, cyc_used, a0, b0, ar0, br0, nrdv;
        bit got;

        #1;
        do_reset(3);
        chk("post_reset_err", err_unexpected_data, 0);

        // A streams 32 reads, B idle
        mem_lat = 3; a0 = n_a_acc; ar0 = n_a_rdv; br0 = n_b_rdv;
        cnt = 0; cyc_used = 0;
        a_read = 1'b1; a_address = 29'd1000;
        while (cnt < 32 && cyc_used < 200) begin
            tick(); cyc_used++;
            if (a_acc_now) begin cnt++; a_address = a_address + 29'd1; end
        end
        a_read = 1'b0;
        chk("p1_cycles_for_32", cyc_used, 32);
        drain();
        chk("p1_a_acc", n_a_acc - a0, 32);
        chk("p1_a_rdv", n_a_rdv - ar0, 32);
        chk("p1_b_rdv", n_b_rdv - br0, 0);

        // A, B, A reads with latency 10: returns in issue order
        mem_lat = 10; ret_order.delete();
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            if (k == 1) begin b_read = 1'b1; b_address = 29'd2000; end
            else begin a_read = 1'b1; a_address = 29'(3000 + k); end
            for (int i = 0; i < 50 && !got; i++) begin
                tick();
                got = (k == 1) ? b_acc_now : a_acc_now;
            end
            a_read = 1'b0; b_read = 1'b0;
            chk("p2_issue_accepted", got, 1);
        end
        drain();
        chk("p2_ret_count", ret_order.size(), 3);
        if (ret_order.size() == 3) begin
            chk("p2_ret0_is_A", ret_order[0], 0);
            chk("p2_ret1_is_B", ret_order[1], 1);
            chk("p2_ret2_is_A", ret_order[2], 0);
        end

        // 64 outstanding reads with no returns: 65th waits for one return
        ret_en = 1'b0; mem_lat = 2; a0 = n_a_acc;
        a_read = 1'b1; a_address = 29'd4000;
        for (int i = 0; i < 90; i++) begin
            tick();
            if (a_acc_now) a_address = a_address + 29'd1;
        end
        chk("p3_acc_at_full", n_a_acc - a0, 64);
        chk("p3_a_wait_full", a_waitrequest, 1);
        nrdv = n_a_rdv;
        ret_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = a_acc_now;
        end
        a_read = 1'b0;
        chk("p3_65th_accepted", got, 1);
        chk("p3_rdv_before_65th", (n_a_rdv > nrdv), 1);
        drain();

        // B write held by mem_waitrequest while A requests: B keeps the master
        a0 = n_a_acc; b0 = n_b_acc;
        mem_waitrequest = 1'b1;
        b_write = 1'b1; b_address = 29'd5000; b_writedata = 64'hDEAD_BEEF_0123_4567; b_byteenable = 8'h3C;
        tick();
        a_read = 1'b1; a_address = 29'd6000;
        for (int i = 0; i < 5; i++) tick();
        chk("p4_no_a_during_hold", n_a_acc - a0, 0);
        chk("p4_no_b_during_hold", n_b_acc - b0, 0);
        mem_waitrequest = 1'b0;
        tick();
        chk("p4_b_accepted", b_acc_now, 1);
        b_write = 1'b0;
        tick();
        chk("p4_a_next", a_acc_now, 1);
        a_read = 1'b0;
        drain();

        // A streams continuously while B write is pending
        mem_lat = 1; cnt = 0; got = 1'b0;
        a_read = 1'b1; a_address = 29'd7000;
        b_write = 1'b1; b_address = 29'd8000; b_writedata = 64'h1122_3344_5566_7788; b_byteenable = 8'hF0;
        for (int i = 0; i < 120 && !got; i++) begin
            tick();
            if (a_acc_now) begin cnt++; a_address = a_address + 29'd1; end
            if (b_acc_now) begin got = 1'b1; b_write = 1'b0; end
        end
`ifdef SDRAM_ARBITER_STARVATION_GUARD_EN
        chk("p5_b_accepted", got, 1);
        chk("p5_a_before_b", cnt, 32);
`else
        chk("p5_b_starved", got, 0);
        chk("p5_a_streamed", cnt, 120);
`endif
        a_read = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (b_acc_now) begin got = 1'b1; b_write = 1'b0; end
        end
        chk("p5_b_after_a_stops", got, 1);
        drain();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            mem_waitrequest = ($urandom_range(0, 3) == 0);
            mem_lat = $urandom_range(1, 12);
            tick();
            if (a_acc_now) a_read = 1'b0;
            if (b_acc_now) begin b_read = 1'b0; b_write = 1'b0; end
            if (!a_read && $urandom_range(0, 2) == 0) begin
                a_read = 1'b1; a_address = 29'($urandom);
            end
            if (!b_read && !b_write && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) b_read = 1'b1; else b_write = 1'b1;
                b_address = 29'($urandom); b_writedata = {$urandom, $urandom};
                b_byteenable = 8'($urandom);
            end
        end
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            mem_waitrequest = 1'b0;
            if (!a_read && !b_read && !b_write) got = 1'b1;
            else begin
                tick();
                if (a_acc_now) a_read = 1'b0;
                if (b_acc_now) begin b_read = 1'b0; b_write = 1'b0; end
            end
        end
        chk("rand_quiesce", got, 1);
        drain();

        // Unexpected read data: sticky error until reset
        inject = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("err_set", err_unexpected_data, 1);
        for (int i = 0; i < 10; i++) tick();
        chk("err_sticky", err_unexpected_data, 1);

        // Reset mid-operation with reads outstanding
        mem_lat = 6;
        a_read = 1'b1; a_address = 29'd9000;
        for (int i = 0; i < 4; i++) tick();
        a_read = 1'b0;
        do_reset(2);
        chk("err_cleared", err_unexpected_data, 0);
        for (int i = 0; i < 15; i++) tick();
        chk("err_after_reset", err_unexpected_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
